// File: rtl/image_conv_requant_pkg.sv
// Shared defaults for the image convolution requantization slice.
// Holds the default lane widths and the helper that maps (channel, pixel)
// onto the flat lane index used by s_data / m_data.
package image_conv_requant_pkg;

    localparam int DEF_WIDTH_ACC   = 48;
    localparam int DEF_WIDTH_SCALE = 32;
    localparam int DEF_WIDTH_SHIFT = 6;
    localparam int DEF_WIDTH_OUT   = 8;
    localparam int DEF_CH_OUT      = 8;
    localparam int DEF_PIX_NUM     = 1;
    localparam int DEF_MULT_STAGES = 2;

    // Lane k for channel j, pixel i: pixels of one channel are adjacent.
    function automatic int lane_idx(input int j, input int i, input int pix_num);
        return j * pix_num + i;
    endfunction

endpackage

// File: rtl/image_conv_requant_lane.sv
// One requantization lane: input register, pipelined signed multiply by the
// channel scale, rounded arithmetic right shift, optional ReLU, zero-point add
// and unsigned saturation into the output register.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   en_i           shared pipeline stage enable
//   load_in_i      capture acc_i into the input register (beat accepted)
//   load_out_i     capture the saturated result (valid beat entering output)
//   acc_i          signed accumulator value
//   scale_i        unsigned per-channel scale
//   shift_i        per-channel right shift amount
//   zp_i, relu_i   output zero point and ReLU enable
//   data_o         saturated unsigned output
module image_conv_requant_lane
    import image_conv_requant_pkg::*;
#(
    parameter int WIDTH_ACC   = DEF_WIDTH_ACC,
    parameter int WIDTH_SCALE = DEF_WIDTH_SCALE,
    parameter int WIDTH_SHIFT = DEF_WIDTH_SHIFT,
    parameter int WIDTH_OUT   = DEF_WIDTH_OUT,
    parameter int MULT_STAGES = DEF_MULT_STAGES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   load_in_i,
    input  logic                   load_out_i,
    input  logic [WIDTH_ACC-1:0]   acc_i,
    input  logic [WIDTH_SCALE-1:0] scale_i,
    input  logic [WIDTH_SHIFT-1:0] shift_i,
    input  logic [WIDTH_OUT-1:0]   zp_i,
    input  logic                   relu_i,
    output logic [WIDTH_OUT-1:0]   data_o
);

    localparam int WP = WIDTH_ACC + WIDTH_SCALE + 1;

    logic signed [WIDTH_ACC-1:0] acc_q;
    logic signed [WP-1:0]        a_ext;
    logic signed [WP-1:0]        s_ext;
    logic signed [WP-1:0]        prod;
    logic signed [WP-1:0]        p_q [MULT_STAGES];
    logic signed [WP-1:0]        p_last;
    logic signed [WP:0]          rnd;
    logic signed [WP:0]          sum_w;
    logic signed [WP-1:0]        r_d;
    logic signed [WP-1:0]        r_q;
    logic signed [WP-1:0]        v;
    logic signed [WP:0]          y;
    logic [WIDTH_OUT-1:0]        out_d;
    logic [WIDTH_OUT-1:0]        out_q;

    // Scale is zero-extended so it always multiplies as a positive value.
    assign a_ext  = WP'(acc_q);
    assign s_ext  = WP'(scale_i);
    assign prod   = a_ext * s_ext;
    assign p_last = p_q[MULT_STAGES-1];

    // Round half up: add 2^(sh-1) one bit wider than P so it cannot overflow.
    always_comb begin
        rnd = '0;
        if (shift_i != '0) begin
            rnd = (WP+1)'(1) << (shift_i - 1'b1);
        end
        sum_w = $signed({p_last[WP-1], p_last}) + rnd;
        r_d   = WP'(sum_w >>> shift_i);
    end

    always_comb begin
        v = (relu_i && r_q[WP-1]) ? '0 : r_q;
        y = $signed({v[WP-1], v}) + $signed({{(WP+1-WIDTH_OUT){1'b0}}, zp_i});
        if (y[WP]) begin
            out_d = '0;
        end else if (|y[WP-1:WIDTH_OUT]) begin
            out_d = '1;
        end else begin
            out_d = y[WIDTH_OUT-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            for (int s = 0; s < MULT_STAGES; s++) begin
                p_q[s] <= '0;
            end
            r_q   <= '0;
            out_q <= '0;
        end else begin
            if (load_in_i) begin
                acc_q <= acc_i;
            end
            if (en_i) begin
                p_q[0] <= prod;
                for (int s = 1; s < MULT_STAGES; s++) begin
                    p_q[s] <= p_q[s-1];
                end
                r_q <= r_d;
            end
            // Only real beats update the output so m_data holds through bubbles.
            if (load_out_i) begin
                out_q <= out_d;
            end
        end
    end

    assign data_o = out_q;

endmodule

// File: rtl/image_conv_requant.sv
// Per-channel requantization stage between the accumulator/bias adder and the
// output packer. Every lane is multiplied by its channel scale, rounded and
// shifted, optionally ReLU'd, offset by the zero point and saturated.
// Ports:
//   clk, rst                  clock, async active-low reset
//   s_valid/s_ready/s_data    accumulator beat in (PIX_NUM*CH_OUT lanes)
//   m_valid/m_ready/m_data    requantized beat out (same lane ordering)
//   cfg_valid/cfg_ready       config load handshake, accepted only when drained
//   cfg_scale/shift/zp/relu   per-channel scale and shift, global zp and ReLU
//   busy                      any pipeline stage holds a valid beat
module image_conv_requant
    import image_conv_requant_pkg::*;
#(
    parameter int WIDTH_ACC   = DEF_WIDTH_ACC,
    parameter int WIDTH_SCALE = DEF_WIDTH_SCALE,
    parameter int WIDTH_SHIFT = DEF_WIDTH_SHIFT,
    parameter int WIDTH_OUT   = DEF_WIDTH_OUT,
    parameter int CH_OUT      = DEF_CH_OUT,
    parameter int PIX_NUM     = DEF_PIX_NUM,
    parameter int MULT_STAGES = DEF_MULT_STAGES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [WIDTH_ACC*PIX_NUM*CH_OUT-1:0] s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [WIDTH_OUT*PIX_NUM*CH_OUT-1:0] m_data,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [WIDTH_SCALE*CH_OUT-1:0]   cfg_scale,
    input  logic [WIDTH_SHIFT*CH_OUT-1:0]   cfg_shift,
    input  logic [WIDTH_OUT-1:0]            cfg_zp,
    input  logic                            cfg_relu,
    output logic                            busy
);

    // Valid chain: [0] input reg, [1..M] multiplier, [M+1] round, [M+2] output.
    localparam int NV = MULT_STAGES + 3;

    logic [1:0]                    rst_sync_q;
    logic                          rst_ok;
    logic [NV-1:0]                 vld_q;
    logic [NV-1:0]                 vld_d;
    logic                          en;
    logic                          accept;
    logic                          load_out;
    logic                          cfg_accept;
    logic [WIDTH_SCALE*CH_OUT-1:0] scale_q;
    logic [WIDTH_SHIFT*CH_OUT-1:0] shift_q;
    logic [WIDTH_OUT-1:0]          zp_q;
    logic                          relu_q;

    // Reset asserts immediately; release reaches the handshakes two edges later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_ok = rst_sync_q[1];

    assign en       = !vld_q[NV-1] || m_ready;
    // Any cfg_valid blocks input: a pending request drains the pipeline, and
    // when already drained the config wins over a simultaneous beat.
    assign s_ready  = rst_ok && en && !cfg_valid;
    assign accept   = s_valid && s_ready;
    assign load_out = en && vld_q[NV-2];

    assign busy       = |vld_q;
    assign m_valid    = vld_q[NV-1];
    assign cfg_ready  = rst_ok && !busy;
    assign cfg_accept = cfg_valid && cfg_ready;

    always_comb begin
        vld_d = {vld_q[NV-2:0], accept};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scale_q <= '0;
            shift_q <= '0;
            zp_q    <= '0;
            relu_q  <= 1'b0;
        end else if (cfg_accept) begin
            scale_q <= cfg_scale;
            shift_q <= cfg_shift;
            zp_q    <= cfg_zp;
            relu_q  <= cfg_relu;
        end
    end

    for (genvar j = 0; j < CH_OUT; j++) begin : g_ch
        for (genvar i = 0; i < PIX_NUM; i++) begin : g_pix
            localparam int K = lane_idx(j, i, PIX_NUM);
            image_conv_requant_lane #(
                .WIDTH_ACC  (WIDTH_ACC),
                .WIDTH_SCALE(WIDTH_SCALE),
                .WIDTH_SHIFT(WIDTH_SHIFT),
                .WIDTH_OUT  (WIDTH_OUT),
                .MULT_STAGES(MULT_STAGES)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst),
                .en_i      (en),
                .load_in_i (accept),
                .load_out_i(load_out),
                .acc_i     (s_data[K*WIDTH_ACC +: WIDTH_ACC]),
                .scale_i   (scale_q[j*WIDTH_SCALE +: WIDTH_SCALE]),
                .shift_i   (shift_q[j*WIDTH_SHIFT +: WIDTH_SHIFT]),
                .zp_i      (zp_q),
                .relu_i    (relu_q),
                .data_o    (m_data[K*WIDTH_OUT +: WIDTH_OUT])
            );
        end
    end

endmodule

// File: tb/tb_image_conv_requant.sv
module tb_image_conv_requant;

    localparam int WA  = 48;
    localparam int WS  = 32;
    localparam int WSH = 6;
    localparam int WO  = 8;
    localparam int CH  = 8;
    localparam int PIX = 2;
    localparam int MS  = 2;
    localparam int L   = CH * PIX;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [L*WA-1:0]   s_data;
    logic              m_valid;
    logic              m_ready;
    logic [L*WO-1:0]   m_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH*WS-1:0]  cfg_scale;
    logic [CH*WSH-1:0] cfg_shift;
    logic [WO-1:0]     cfg_zp;
    logic              cfg_relu;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    image_conv_requant #(
        .WIDTH_ACC(WA), .WIDTH_SCALE(WS), .WIDTH_SHIFT(WSH), .WIDTH_OUT(WO),
        .CH_OUT(CH), .PIX_NUM(PIX), .MULT_STAGES(MS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_relu(cfg_relu),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(input longint acc, input longint scale,
                                         input int sh, input int zp, input bit relu);
        longint p, r, y;
        p = acc * scale;
        if (sh == 0) r = p;
        else r = (p + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && r < 0) r = 0;
        y = r + longint'(zp);
        if (y < 0) return 8'd0;
        if (y > 255) return 8'd255;
        return y[7:0];
    endfunction

    // Beat for the (scale=j+1, shift=1, zp=100, relu=0) config: lane k gets base+3k.
    task automatic build_beat(input int base, output logic [L*WA-1:0] sv, output logic [L*WO-1:0] ev);
        for (int k = 0; k < L; k++) begin
            sv[k*WA +: WA] = 48'(base + 3*k);
            ev[k*WO +: WO] = ref_q(longint'(base + 3*k), longint'(k/PIX + 1), 1, 100, 1'b0);
        end
    endtask

    task automatic do_cfg(input logic [CH*WS-1:0] sc, input logic [CH*WSH-1:0] sh,
                          input logic [7:0] zp, input logic relu);
        int n;
        cfg_scale = sc; cfg_shift = sh; cfg_zp = zp; cfg_relu = relu;
        cfg_valid = 1'b1;
        n = 0;
        #1;
        while (!cfg_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check("cfg_handshake", 128'(n < 100), 128'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Sends one beat with every lane = acc, waits for the result, checks it.
    task automatic run_beat(input string tag, input logic [WA-1:0] acc,
                            input logic [L*WO-1:0] exp, output int lat);
        int n;
        s_data  = {L{acc}};
        s_valid = 1'b1;
        n = 0;
        #1;
        while (!s_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_accept"}, 128'(n < 50), 128'd1);
        @(negedge clk);
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 50) begin
            @(negedge clk); lat++;
        end
        check({tag, "_valid"}, 128'(m_valid), 128'd1);
        check(tag, 128'(m_data), 128'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CH*WS-1:0]  sc;
        logic [L*WO-1:0]   ev;
        logic [L*WA-1:0]   sv;
        logic [L*WO-1:0]   exp_q[$];
        logic [L*WO-1:0]   held;
        int lat, sent, recv, cyc, base, acc_cnt, mv_cnt, first_mv, last_mv, got, n;
        bit hold, took, done;

        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        cfg_valid = 1'b0; cfg_scale = '0; cfg_shift = '0; cfg_zp = '0; cfg_relu = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 128'(s_ready), 128'd0);
        check("rst_m_valid", 128'(m_valid), 128'd0);
        check("rst_m_data", 128'(m_data), 128'd0);
        check("rst_cfg_ready", 128'(cfg_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);

        rst = 1'b1;
        #1 check("rel_edge0_s_ready", 128'(s_ready), 128'd0);
        @(negedge clk);
        check("rel_edge1_s_ready", 128'(s_ready), 128'd0);
        @(negedge clk);
        check("rel_edge2_s_ready", 128'(s_ready), 128'd1);
        check("rel_edge2_cfg_ready", 128'(cfg_ready), 128'd1);

        // Basic requant: scale 3, shift 2, zp 10.
        do_cfg({CH{32'd3}}, {CH{6'd2}}, 8'd10, 1'b0);
        run_beat("basic_pos13", 48'd13, {L{8'd20}}, lat);
        check("basic_latency", 128'(lat), 128'(MS + 3));
        run_beat("basic_neg13", -48'sd13, {L{8'd0}}, lat);

        // ReLU and saturation: scale 1, shift 0, zp 128.
        do_cfg({CH{32'd1}}, {CH{6'd0}}, 8'd128, 1'b1);
        run_beat("relu_on_neg50", -48'sd50, {L{8'd128}}, lat);
        do_cfg({CH{32'd1}}, {CH{6'd0}}, 8'd128, 1'b0);
        run_beat("relu_off_neg50", -48'sd50, {L{8'd78}}, lat);
        run_beat("sat_hi_200", 48'd200, {L{8'd255}}, lat);
        run_beat("sat_lo_neg200", -48'sd200, {L{8'd0}}, lat);
        run_beat("sat_acc_max", 48'h7FFF_FFFF_FFFF, {L{8'd255}}, lat);
        run_beat("sat_acc_min", 48'h8000_0000_0000, {L{8'd0}}, lat);

        // Rounding at the half point: scale 1, shift 1, zp 10.
        do_cfg({CH{32'd1}}, {CH{6'd1}}, 8'd10, 1'b0);
        run_beat("round_neg3", -48'sd3, {L{8'd9}}, lat);
        run_beat("round_pos3", 48'd3, {L{8'd12}}, lat);
        run_beat("round_neg1", -48'sd1, {L{8'd10}}, lat);

        // Scale MSB set must multiply as unsigned: 3*2^31 + 2^30 >> 31 = 3.
        do_cfg({CH{32'h8000_0000}}, {CH{6'd31}}, 8'd0, 1'b0);
        run_beat("scale_msb", 48'd3, {L{8'd3}}, lat);

        // Per-channel scales j+1, lane ordering k = j*PIX + i.
        for (int j = 0; j < CH; j++) sc[j*WS +: WS] = 32'(j + 1);
        do_cfg(sc, {CH{6'd0}}, 8'd0, 1'b0);
        for (int k = 0; k < L; k++) ev[k*WO +: WO] = 8'(5 * (k/PIX + 1));
        run_beat("per_channel", 48'd5, ev, lat);

        // Backpressure stream: scale j+1, shift 1, zp 100, random m_ready.
        do_cfg(sc, {CH{6'd1}}, 8'd100, 1'b0);
        sent = 0; recv = 0; cyc = 0; hold = 1'b0; took = 1'b0; held = '0;
        while (recv < 20 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (hold) begin
                check("bp_hold_valid", 128'(m_valid), 128'd1);
                check("bp_hold_data", 128'(m_data), 128'(held));
            end
            if (took) s_valid = 1'b0;
            if (sent < 20 && !s_valid) begin
                base = int'($urandom_range(120)) - 60;
                build_beat(base, sv, ev);
                s_data = sv;
                s_valid = 1'b1;
            end
            m_ready = 1'($urandom_range(1));
            #1;
            took = s_valid && s_ready;
            if (took) begin
                exp_q.push_back(ev);
                sent++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_unexpected_beat", 128'd1, 128'd0);
                end else begin
                    check("bp_data", 128'(m_data), 128'(exp_q.pop_front()));
                end
                recv++;
            end
            hold = m_valid && !m_ready;
            held = m_data;
        end
        check("bp_recv_count", 128'(recv), 128'd20);
        check("bp_queue_empty", 128'(exp_q.size()), 128'd0);

        // Throughput with m_ready held high: 8 beats in 8 cycles, out back-to-back.
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b1;
        acc_cnt = 0; mv_cnt = 0; first_mv = -1; last_mv = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            s_valid = (c < 8);
            s_data = {L{48'(c)}};
            #1;
            if (s_valid && s_ready) acc_cnt++;
            if (m_valid) begin
                mv_cnt++;
                if (first_mv < 0) first_mv = c;
                last_mv = c;
            end
        end
        s_valid = 1'b0;
        check("tp_accepted", 128'(acc_cnt), 128'd8);
        check("tp_out_count", 128'(mv_cnt), 128'd8);
        check("tp_out_span", 128'(last_mv - first_mv + 1), 128'd8);

        // Config during traffic: three old-config beats then a new config.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            build_beat(7 + 20*c, sv, ev);
            s_data = sv; s_valid = 1'b1;
            #1;
            check("cfgt_pre_s_ready", 128'(s_ready), 128'd1);
            exp_q.push_back(ev);
        end
        @(negedge clk);
        s_data = {L{48'd11}}; s_valid = 1'b1;
        cfg_scale = {CH{32'd2}}; cfg_shift = '0; cfg_zp = 8'd0; cfg_relu = 1'b0;
        cfg_valid = 1'b1;
        got = 0; done = 1'b0; n = 0;
        while (!done && n < 50) begin
            #1;
            check("cfgt_s_ready_low", 128'(s_ready), 128'd0);
            if (m_valid) begin
                if (exp_q.size() == 0) check("cfgt_extra_beat", 128'd1, 128'd0);
                else check("cfgt_old_data", 128'(m_data), 128'(exp_q.pop_front()));
                got++;
            end
            if (cfg_ready) begin
                check("cfgt_ready_drained", 128'({busy, m_valid}), 128'd0);
                done = 1'b1;
            end else begin
                @(negedge clk); n++;
            end
        end
        check("cfgt_ready_seen", 128'(done), 128'd1);
        check("cfgt_old_count", 128'(got), 128'd3);
        @(negedge clk);
        cfg_valid = 1'b0;
        run_beat("cfgt_new_scale", 48'd11, {L{8'd22}}, lat);

        // Reset with three beats in flight.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_data = {L{48'(40 + c)}}; s_valid = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_m_valid", 128'(m_valid), 128'd0);
        check("midrst_m_data", 128'(m_data), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_s_ready", 128'(s_ready), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        mv_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (m_valid) mv_cnt++;
        end
        check("midrst_no_emit", 128'(mv_cnt), 128'd0);
        run_beat("midrst_post_beat", 48'd1234, {L{8'd0}}, lat);
        check("midrst_post_latency", 128'(lat), 128'(MS + 3));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
